// File: rtl/play_btn_debounce.sv
// play_btn_debounce: synchronizes, debounces and classifies one board push-button.
// btn_level is the clean pressed level that feeds the PIO in_port. The three strobes
// (press, release, long) are one cycle wide and never overlap. long_press stays high
// from the long strobe until the debounced release.
module play_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic long_press
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Pad value while the button is not pressed.
    localparam logic RELEASED = ACTIVE_LOW;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t            state, state_d;
    logic [DB_W-1:0]   db_cnt, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic              ret_held, ret_held_d;
    logic              level_d, press_d, release_d, long_d, long_press_d;

    logic sync1, sync2;
    logic pressed;

    // Two-flop synchronizer. It resets to the released pad value, so a button that is
    // held down while reset deasserts is seen as a new press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1 value, which gives a real two-stage chain.
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Normalize polarity so that 1 always means pressed.
    assign pressed = sync2 ^ ACTIVE_LOW;

    // Next-state logic: debounce counting, hold timing and output strobes.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave a value unassigned and infer a latch.
        state_d      = state;
        db_cnt_d     = db_cnt;
        hold_cnt_d   = hold_cnt;
        ret_held_d   = ret_held;
        level_d      = btn_level;
        long_press_d = long_press;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;

        case (state)
            IDLE: begin
                level_d      = 1'b0;
                long_press_d = 1'b0;
                if (pressed) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!pressed) begin
                    // Glitch: drop it without touching any output.
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d    = PRESSED;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                end else begin
                    db_cnt_d = db_cnt + DB_ONE;
                end
            end

            PRESSED: begin
                if (!pressed) begin
                    state_d    = RELEASE_WAIT;
                    db_cnt_d   = DB_ONE;
                    ret_held_d = 1'b0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d      = HELD;
                    long_press_d = 1'b1;
                    long_d       = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_ONE;
                end
            end

            HELD: begin
                // hold_cnt stays saturated here.
                if (!pressed) begin
                    state_d    = RELEASE_WAIT;
                    db_cnt_d   = DB_ONE;
                    ret_held_d = 1'b1;
                end
            end

            RELEASE_WAIT: begin
                // btn_level and long_press keep their values, and hold_cnt is frozen.
                if (pressed) begin
                    // Release bounce: go back to where we came from with no strobe.
                    state_d  = ret_held ? HELD : PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d      = IDLE;
                    db_cnt_d     = '0;
                    level_d      = 1'b0;
                    long_press_d = 1'b0;
                    release_d    = 1'b1;
                end else begin
                    db_cnt_d = db_cnt + DB_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs. All of them clear at once on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            ret_held      <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_d;
            db_cnt        <= db_cnt_d;
            hold_cnt      <= hold_cnt_d;
            ret_held      <= ret_held_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            long_press    <= long_press_d;
        end
    end

endmodule

// File: tb/tb_play_btn_debounce.sv
// Testbench for play_btn_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, ACTIVE_LOW=1.
// Each scenario is a list of btn_raw segments plus the edge indices at which btn_level
// should rise and fall and long_pulse should fire. Edge 0 is the first rising edge
// that samples the scenario's first segment.
module tb_play_btn_debounce;

    localparam int D = 4;
    localparam int H = 20;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_raw;
    logic btn_level, press_pulse, release_pulse, long_pulse, long_press;
    logic [4:0] act;

    int n_vec = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        string           name;
        int              nseg;
        logic [3:0]      lvl;   // lvl[i] is the btn_raw level of segment i
        logic [3:0][7:0] len;   // len[i] is the length of segment i in edges
        int              rise;  // edge where btn_level rises (-1: never)
        int              fall;  // edge where btn_level falls (-1: never)
        int              longp; // edge where long_pulse fires (-1: never)
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    play_btn_debounce #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .long_press   (long_press)
    );

    assign act = {btn_level, press_pulse, release_pulse, long_pulse, long_press};

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b {level,press,release,long_pulse,long_press}",
                     name, got, want);
        end
    endtask

    // Drive one input at the falling edge and queue the expected outputs. Then pop the
    // expectation and compare it 1 ns after the next rising edge.
    task automatic step(input string name, input logic raw, input logic [4:0] want);
        @(negedge clk);
        btn_raw = raw;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        check(name, act, exp_q.pop_front());
    endtask

    function automatic vec_t mk(input string n, input int nseg, input logic [3:0] lvl,
                                input int l0, input int l1, input int l2, input int l3,
                                input int r, input int f, input int lp);
        vec_t v;
        v.name   = n;
        v.nseg   = nseg;
        v.lvl    = lvl;
        v.len[0] = 8'(l0);
        v.len[1] = 8'(l1);
        v.len[2] = 8'(l2);
        v.len[3] = 8'(l3);
        v.rise   = r;
        v.fall   = f;
        v.longp  = lp;
        return v;
    endfunction

    function automatic logic [4:0] expect_at(input vec_t v, input int e);
        logic lv, pr, rl, lpu, lpr;
        lv  = (v.rise >= 0) && (e >= v.rise) && (v.fall < 0 || e < v.fall);
        pr  = (e == v.rise);
        rl  = (v.fall >= 0) && (e == v.fall);
        lpu = (e == v.longp);
        lpr = (v.longp >= 0) && (e >= v.longp) && (v.fall < 0 || e < v.fall);
        return {lv, pr, rl, lpu, lpr};
    endfunction

    initial begin
        //            name          nseg lvl      lengths            rise fall long
        vecs[0] = mk("clean_press",   2, 4'b0010, 15, 14,  0,  0,    5,  20,  -1);
        vecs[1] = mk("press_bounce",  4, 4'b1010,  3,  1, 16, 12,    9,  25,  -1);
        vecs[2] = mk("short_tap",     2, 4'b0010,  3, 12,  0,  0,   -1,  -1,  -1);
        vecs[3] = mk("long_press",    2, 4'b0010, 40, 12,  0,  0,    5,  45,  25);
        vecs[4] = mk("rel_bounce",    4, 4'b1010, 12,  2,  1, 14,    5,  20,  -1);
        vecs[5] = mk("held_bounce",   4, 4'b1010, 30,  1,  2, 12,    5,  38,  25);

        // Reset state.
        reset_n = 1'b0;
        btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", act, 5'b00000);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 1'b1, 5'b00000);

        // Table-driven scenarios.
        for (int i = 0; i < 6; i++) begin
            int e;
            e = 0;
            for (int s = 0; s < vecs[i].nseg; s++) begin
                for (int k = 0; k < int'(vecs[i].len[s]); k++) begin
                    step($sformatf("%s@%0d", vecs[i].name, e), vecs[i].lvl[s],
                         expect_at(vecs[i], e));
                    e++;
                end
            end
        end

        // Reset asserted in PRESSED with the button held, then a fresh press after release.
        for (int e = 0; e < 10; e++)
            step($sformatf("rst_pre@%0d", e), 1'b0, {(e >= 5), (e == 5), 3'b000});
        reset_n = 1'b0;
        #1;
        check("rst_async", act, 5'b00000);
        step("rst_hold0", 1'b0, 5'b00000);
        step("rst_hold1", 1'b0, 5'b00000);
        #1;
        reset_n = 1'b1;
        for (int e = 0; e < 8; e++)
            step($sformatf("rst_post@%0d", e), 1'b0, {(e >= 5), (e == 5), 3'b000});
        for (int e = 0; e < 10; e++)
            step($sformatf("rst_rel@%0d", e), 1'b1, {(e < 5), 1'b0, (e == 5), 2'b00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/play_btn_debounce.md
Name: play_btn_debounce

Overview:
Debounce and press-classification front end for a single board push-button. It sits directly upstream of the Avalon PIO button input.
- btn_level drives the PIO in_port, so the PIO edge-capture/IRQ sees exactly one clean rising edge per physical press.
- Also provides one-cycle press, release and long-press strobes for hardware consumers such as the playback control FSM.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive synchronized samples required to accept a level change (10 ms at 50 MHz); legal range >= 2.
HOLD_CYCLES, 50000000, cycles the debounced press must last before long-press is declared (1 s at 50 MHz); must be > DEBOUNCE_CYCLES.
ACTIVE_LOW, 1, 1 = raw pad reads 0 when pressed (DE-series KEY); 0 = raw pad reads 1 when pressed.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
btn_raw  input  1  raw button pad, asynchronous to clk, bouncy
btn_level  output  1  debounced pressed level, 1 = pressed; feeds PIO in_port
press_pulse  output  1  one-cycle strobe on debounced press
release_pulse  output  1  one-cycle strobe on debounced release
long_pulse  output  1  one-cycle strobe when press reaches HOLD_CYCLES
long_press  output  1  level, 1 from long_pulse until debounced release

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FSM in IDLE; counters 0.
  - Synchronizer flops reset to the raw "released" value (1 if ACTIVE_LOW, else 0).
- Input conditioning:
  - btn_raw passes through a 2-flop synchronizer.
  - Result is inverted when ACTIVE_LOW=1, giving s (1 = pressed).
  - Only s is used downstream.
- Counters:
  - db_cnt sized ceil(log2(DEBOUNCE_CYCLES+1)).
  - hold_cnt sized ceil(log2(HOLD_CYCLES+1)).
  - Both unsigned; neither wraps (see saturation rules below).
- FSM states: IDLE, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT.
  - IDLE: btn_level=0. s=1 -> PRESS_WAIT, db_cnt<=1.
  - PRESS_WAIT:
    - s=0 -> IDLE, db_cnt<=0. Glitch is discarded; no output changes.
    - s=1 and db_cnt==DEBOUNCE_CYCLES-1 -> PRESSED; btn_level<=1; press_pulse<=1 for one cycle; hold_cnt<=0.
    - Otherwise db_cnt++.
  - PRESSED:
    - s=1: hold_cnt++. When hold_cnt==HOLD_CYCLES-1 -> HELD; long_press<=1; long_pulse<=1 for one cycle.
    - s=0 -> RELEASE_WAIT, db_cnt<=1, remembering return state PRESSED.
  - HELD:
    - hold_cnt frozen (saturated).
    - s=0 -> RELEASE_WAIT, db_cnt<=1, return state HELD.
  - RELEASE_WAIT:
    - btn_level and long_press keep their values.
    - hold_cnt frozen.
    - s=1 -> back to remembered state; hold_cnt resumes; no pulses.
    - s=0 and db_cnt==DEBOUNCE_CYCLES-1 -> IDLE; btn_level<=0; long_press<=0; release_pulse<=1 for one cycle.
    - Otherwise db_cnt++.
- Latency:
  - A stable pressed input reaches btn_level after DEBOUNCE_CYCLES+2 rising edges from the first edge sampling the new btn_raw level. The 2 is synchronizer delay.
  - Release uses the same latency.
  - long_pulse fires HOLD_CYCLES edges after press_pulse when no release bounce occurs.
- All outputs are registered.
  - press_pulse asserts on the same edge btn_level rises.
  - release_pulse asserts on the same edge btn_level falls.
- Pulses are mutually exclusive; at most one of press/release/long pulse is high in any cycle.
- Button held through reset deassertion is treated as a fresh press: press_pulse after DEBOUNCE_CYCLES+2 edges.
- Reset asserted mid-operation (any state) drops all outputs immediately. No release_pulse is produced.

Test Plan:
All with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, ACTIVE_LOW=1.
1. Clean press: btn_raw 1->0, held 15 cycles, then 1 held -> btn_level and press_pulse rise 6 edges after fall; release_pulse and btn_level fall 6 edges after return to 1; each pulse exactly one cycle.
2. Press bounce: btn_raw 0 for 3 cycles, 1 for 1 cycle, then 0 held -> no pulse during bounce; btn_level rises 6 edges after the final fall; exactly one press_pulse.
3. Short tap: btn_raw 0 for 3 cycles only -> btn_level, press_pulse, release_pulse stay 0 throughout.
4. Long press: btn_raw 0 held 40 cycles -> long_pulse one cycle exactly 20 edges after press_pulse; long_press 1 until btn_level falls after release; one release_pulse.
5. Release bounce: after press, btn_raw 1 for 2 cycles, 0 for 1, then 1 held -> btn_level stays 1 through bounce; single release_pulse 6 edges after last rise; no second press_pulse.
6. Reset: reset_n low during PRESSED with btn_raw held 0 -> outputs 0 immediately; after reset_n high, press_pulse and btn_level rise 6 edges later.
